// File: rtl/qsort_pkg.sv
// Shared types for the quicksort range scheduler: index width, (lo,hi) range
// record and the controller state encoding.
package qsort_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int DEFAULT_DEPTH = 4096;
    localparam int DEFAULT_SP_W  = 12;

    typedef struct packed {
        logic [WORD_SIZE-1:0] lo;
        logic [WORD_SIZE-1:0] hi;
    } range_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEED      = 3'd1,
        ST_POP       = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_PART = 3'd4,
        ST_PUSH_A    = 3'd5,
        ST_PUSH_B    = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

endpackage

// File: rtl/range_lifo_mem.sv
// Range stack storage: one write port and one synchronous read port.
// The read register is reset so the issued range reads as zero after reset.
module range_lifo_mem #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/qsort_range_scheduler.sv
// Quicksort range sequencer: keeps pending (lo,hi) ranges on a LIFO, hands one at
// a time to the partition engine and pushes the resulting sub-ranges back.
module qsort_range_scheduler
    import qsort_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SP_W  = DEFAULT_SP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] init_lo,
    input  logic [WORD_SIZE-1:0] init_hi,
    output logic                 range_valid,
    input  logic                 range_ready,
    output logic [WORD_SIZE-1:0] range_lo,
    output logic [WORD_SIZE-1:0] range_hi,
    input  logic                 part_done,
    input  logic [WORD_SIZE-1:0] pivot_idx,
    output logic                 busy,
    output logic                 sort_done,
    output logic                 overflow,
    output logic [SP_W:0]        depth,
    output logic [2:0]           dbg_state
);

    // Handshake: a range transfers on a rising edge where range_valid and
    // range_ready are both high; range_lo/hi stay stable while valid waits.

    localparam logic [SP_W:0] SP_ONE  = (SP_W+1)'(1);
    localparam logic [SP_W:0] SP_FULL = (SP_W+1)'(DEPTH);

    state_e               state_q, state_d;
    logic [SP_W:0]        sp_q, sp_d, sp_m1;
    logic                 ovf_q, ovf_d;
    logic                 has_b_q, has_b_d;
    range_t               push_a_q, push_a_d, push_b_q, push_b_d;

    logic                 wr_en, rd_en;
    logic [SP_W-1:0]      wr_addr, rd_addr;
    range_t               wr_data, cur;

    logic [WORD_SIZE-1:0] p_m1;
    logic [WORD_SIZE:0]   p_p1;
    logic                 l_ok, r_ok, l_first;
    range_t               l_rng, r_rng;

    range_lifo_mem #(
        .DEPTH (DEPTH),
        .AW    (SP_W),
        .DW    ($bits(range_t))
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (cur)
    );

    // The issued range stays in the read register until the next pop, so it
    // doubles as the (lo,hi) reference for the sub-range arithmetic.
    assign sp_m1   = sp_q - SP_ONE;
    assign wr_addr = sp_q[SP_W-1:0];
    assign rd_addr = sp_m1[SP_W-1:0];

    // p-1 is only meaningful when p>lo; p+1 carries an extra bit so p=max never wraps.
    assign p_m1    = pivot_idx - 1'b1;
    assign p_p1    = {1'b0, pivot_idx} + 1'b1;
    assign l_ok    = (pivot_idx > cur.lo) && (p_m1 > cur.lo);
    assign r_ok    = p_p1 < {1'b0, cur.hi};
    assign l_rng   = {cur.lo, p_m1};
    assign r_rng   = {p_p1[WORD_SIZE-1:0], cur.hi};
    assign l_first = l_ok && (!r_ok || ((pivot_idx - cur.lo) >= (cur.hi - pivot_idx)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sp_q     <= '0;
            ovf_q    <= 1'b0;
            has_b_q  <= 1'b0;
            push_a_q <= '0;
            push_b_q <= '0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            ovf_q    <= ovf_d;
            has_b_q  <= has_b_d;
            push_a_q <= push_a_d;
            push_b_q <= push_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        ovf_d    = ovf_q;
        has_b_d  = has_b_q;
        push_a_d = push_a_q;
        push_b_d = push_b_q;
        wr_en    = 1'b0;
        wr_data  = push_a_q;
        rd_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    sp_d  = '0;
                    if (init_lo < init_hi) begin
                        push_a_d = {init_lo, init_hi};
                        state_d  = ST_SEED;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEED: begin
                wr_en   = 1'b1;
                sp_d    = sp_q + SP_ONE;
                state_d = ST_POP;
            end
            ST_POP: begin
                if (sp_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    rd_en   = 1'b1;
                    sp_d    = sp_m1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (range_ready) begin
                    state_d = ST_WAIT_PART;
                end
            end
            ST_WAIT_PART: begin
                if (part_done) begin
                    push_a_d = l_first ? l_rng : r_rng;
                    push_b_d = l_first ? r_rng : l_rng;
                    has_b_d  = l_ok && r_ok;
                    state_d  = (l_ok || r_ok) ? ST_PUSH_A : ST_POP;
                end
            end
            ST_PUSH_A, ST_PUSH_B: begin
                wr_data = (state_q == ST_PUSH_A) ? push_a_q : push_b_q;
                if (sp_q == SP_FULL) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wr_en   = 1'b1;
                    sp_d    = sp_q + SP_ONE;
                    state_d = (state_q == ST_PUSH_A && has_b_q) ? ST_PUSH_B : ST_POP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign range_valid = (state_q == ST_ISSUE);
    assign range_lo    = cur.lo;
    assign range_hi    = cur.hi;
    assign busy        = (state_q != ST_IDLE);
    assign sort_done   = (state_q == ST_DONE);
    assign overflow    = ovf_q;
    assign depth       = sp_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_qsort_range_scheduler.sv
// Bench for qsort_range_scheduler: a behavioural partition engine plus a software
// range stack predict every issued range, latency, depth and overflow outcome.
module tb_qsort_range_scheduler;
    import qsort_pkg::*;

    localparam int WS = WORD_SIZE;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [WS-1:0] init_lo, init_hi;
    logic          range_ready;
    logic          part_done;
    logic [WS-1:0] pivot_idx;
    logic          sel_small;

    logic          b_valid, b_busy, b_done, b_ovf;
    logic [WS-1:0] b_lo, b_hi;
    logic [12:0]   b_depth;
    logic [2:0]    b_state;

    logic          s_valid, s_busy, s_done, s_ovf;
    logic [WS-1:0] s_lo, s_hi;
    logic [2:0]    s_depth;
    logic [2:0]    s_state;

    logic          m_valid, m_busy, m_done, m_ovf;
    logic [WS-1:0] m_lo, m_hi;
    logic [2:0]    m_state;
    int            m_depth;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   stk[$];
    int            piv_q[$];
    int            cov[16];

    always #5 clk = ~clk;

    qsort_range_scheduler dut_big (
        .clk(clk), .reset(reset), .start(start && !sel_small),
        .init_lo(init_lo), .init_hi(init_hi),
        .range_valid(b_valid), .range_ready(range_ready),
        .range_lo(b_lo), .range_hi(b_hi),
        .part_done(part_done), .pivot_idx(pivot_idx),
        .busy(b_busy), .sort_done(b_done), .overflow(b_ovf),
        .depth(b_depth), .dbg_state(b_state)
    );

    qsort_range_scheduler #(.DEPTH(4), .SP_W(2)) dut_small (
        .clk(clk), .reset(reset), .start(start && sel_small),
        .init_lo(init_lo), .init_hi(init_hi),
        .range_valid(s_valid), .range_ready(range_ready),
        .range_lo(s_lo), .range_hi(s_hi),
        .part_done(part_done), .pivot_idx(pivot_idx),
        .busy(s_busy), .sort_done(s_done), .overflow(s_ovf),
        .depth(s_depth), .dbg_state(s_state)
    );

    assign m_valid = sel_small ? s_valid : b_valid;
    assign m_busy  = sel_small ? s_busy  : b_busy;
    assign m_done  = sel_small ? s_done  : b_done;
    assign m_ovf   = sel_small ? s_ovf   : b_ovf;
    assign m_lo    = sel_small ? s_lo    : b_lo;
    assign m_hi    = sel_small ? s_hi    : b_hi;
    assign m_state = sel_small ? s_state : b_state;
    assign m_depth = sel_small ? int'(s_depth) : int'(b_depth);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference partition bookkeeping: larger valid sub-range pushed first (tie: left).
    task automatic model_part(input int lo, input int hi, input int p, input int cap,
                              output int pushes, output bit ovf);
        bit          l_ok, r_ok, l_first;
        logic [31:0] first, second;
        int          n;
        l_ok    = (p > lo) && (p - 1 > lo);
        r_ok    = (p + 1 < hi);
        l_first = l_ok && (!r_ok || (p - lo >= hi - p));
        if (p < 16) cov[p]++;
        if (p > lo && p - 1 == lo && lo < 16) cov[lo]++;
        if (p + 1 == hi && hi < 16) cov[hi]++;
        first  = l_first ? {16'(lo), 16'(p - 1)} : {16'(p + 1), 16'(hi)};
        second = l_first ? {16'(p + 1), 16'(hi)} : {16'(lo), 16'(p - 1)};
        n      = (l_ok ? 1 : 0) + (r_ok ? 1 : 0);
        pushes = 0;
        ovf    = 1'b0;
        for (int k = 0; k < n; k++) begin
            pushes++;
            if (stk.size() == cap) begin
                ovf = 1'b1;
                break;
            end
            stk.push_back(k == 0 ? first : second);
        end
    endtask

    task automatic run_sort(input int lo, input int hi, input bit mid, input bit rnd_ready,
                            input int cap, input int stop_after);
        int          c, exp_lat, served, pushes, cur_lo, cur_hi, p, h;
        bit          exp_end, exp_ovf, ovf;
        logic [31:0] e;
        stk.delete();
        exp_q.delete();
        served  = 0;
        exp_ovf = 1'b0;
        init_lo = WS'(lo);
        init_hi = WS'(hi);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        if (lo < hi) begin
            exp_q.push_back({16'(lo), 16'(hi)});
            exp_lat = 3;
            exp_end = 1'b0;
        end else begin
            exp_lat = 1;
            exp_end = 1'b1;
        end
        c = 1;
        while (served < 400) begin
            while (!m_valid && !m_done && c < 40) begin
                tick();
                c++;
            end
            checks++;
            if (!m_valid && !m_done) begin
                errors++;
                $display("FAIL event_timeout got none after %0d cycles want valid or done", c);
                break;
            end
            checks++;
            if (c != exp_lat) begin
                errors++;
                $display("FAIL latency got %0d want %0d", c, exp_lat);
            end
            if (exp_end) begin
                checks++;
                if (m_done !== 1'b1 || m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL end_event got done=%b valid=%b want done=1 valid=0", m_done, m_valid);
                end
                checks++;
                if (m_state !== ST_DONE) begin
                    errors++;
                    $display("FAIL done_state got %0d want %0d", m_state, ST_DONE);
                end
                checks++;
                if (m_ovf !== exp_ovf) begin
                    errors++;
                    $display("FAIL overflow got %b want %b", m_ovf, exp_ovf);
                end
                checks++;
                if (m_depth != stk.size()) begin
                    errors++;
                    $display("FAIL end_depth got %0d want %0d", m_depth, stk.size());
                end
                tick();
                checks++;
                if (m_done !== 1'b0 || m_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse got done=%b busy=%b want 0 0", m_done, m_busy);
                end
                break;
            end
            if (m_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL early_done got sort_done want range %h", exp_q[0]);
                break;
            end
            e = exp_q.pop_front();
            checks++;
            if ({m_lo, m_hi} !== e) begin
                errors++;
                $display("FAIL issue_range got %h want %h", {m_lo, m_hi}, e);
            end
            checks++;
            if (m_depth != stk.size()) begin
                errors++;
                $display("FAIL issue_depth got %0d want %0d", m_depth, stk.size());
            end
            served++;
            h = 0;
            do begin
                range_ready = (rnd_ready && h < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
                h++;
                if (!range_ready) begin
                    checks++;
                    if (m_valid !== 1'b1 || {m_lo, m_hi} !== e) begin
                        errors++;
                        $display("FAIL hold_stable got v=%b %h want v=1 %h", m_valid, {m_lo, m_hi}, e);
                    end
                end
            end while (!range_ready);
            range_ready = 1'b0;
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_handshake_valid got %b want 0", m_valid);
            end
            if (served == stop_after) break;
            cur_lo = int'(e[31:16]);
            cur_hi = int'(e[15:0]);
            if (piv_q.size() > 0) p = piv_q.pop_front();
            else if (mid) p = (cur_lo + cur_hi) / 2;
            else p = int'($urandom_range(cur_hi, cur_lo));
            repeat ($urandom_range(0, 3)) tick();
            pivot_idx = WS'(p);
            part_done = 1'b1;
            tick();
            part_done = 1'b0;
            model_part(cur_lo, cur_hi, p, cap, pushes, ovf);
            c = 1;
            if (ovf) begin
                exp_ovf = 1'b1;
                exp_end = 1'b1;
                exp_lat = pushes + 1;
            end else if (stk.size() == 0) begin
                exp_end = 1'b1;
                exp_lat = 2;
            end else begin
                exp_q.push_back(stk.pop_back());
                exp_lat = pushes + 2;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if ({b_valid, b_busy, b_done, b_ovf} !== 4'b0 || b_depth !== '0 || {b_lo, b_hi} !== '0) begin
            errors++;
            $display("FAIL reset_big got v%b b%b d%b o%b dep%0d %h want all 0",
                     b_valid, b_busy, b_done, b_ovf, b_depth, {b_lo, b_hi});
        end
        checks++;
        if ({s_valid, s_busy, s_done, s_ovf} !== 4'b0 || s_depth !== '0 || s_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_small got v%b b%b d%b o%b dep%0d st%0d want all 0",
                     s_valid, s_busy, s_done, s_ovf, s_depth, s_state);
        end
    endtask

    task automatic test_empty_range();
        run_sort(0, 0, 1'b0, 1'b0, 4096, -1);
        run_sort(9, 3, 1'b0, 1'b0, 4096, -1);
    endtask

    task automatic test_basic();
        piv_q = '{3, 1};
        run_sort(0, 7, 1'b0, 1'b0, 4096, -1);
    endtask

    task automatic test_single_sided();
        piv_q = '{0};
        run_sort(0, 7, 1'b0, 1'b0, 4096, -1);
        piv_q = '{7};
        run_sort(0, 7, 1'b0, 1'b0, 4096, -1);
        piv_q = '{1};
        run_sort(0, 2, 1'b0, 1'b0, 4096, -1);
    endtask

    task automatic test_full_sort();
        for (int i = 0; i < 16; i++) cov[i] = 0;
        run_sort(0, 15, 1'b0, 1'b1, 4096, -1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cov[i] != 1) begin
                errors++;
                $display("FAIL coverage idx %0d got %0d want 1", i, cov[i]);
            end
        end
    endtask

    task automatic test_top_of_range();
        piv_q = '{65535};
        run_sort(65533, 65535, 1'b0, 1'b0, 4096, -1);
    endtask

    task automatic test_overflow();
        sel_small = 1'b1;
        run_sort(0, 99, 1'b1, 1'b0, 4, -1);
        tick();
        checks++;
        if (m_ovf !== 1'b1 || m_state !== ST_IDLE) begin
            errors++;
            $display("FAIL overflow_sticky got o=%b st=%0d want o=1 st=%0d", m_ovf, m_state, ST_IDLE);
        end
        run_sort(0, 0, 1'b0, 1'b0, 4, -1);
        sel_small = 1'b0;
    endtask

    task automatic test_reset_mid();
        run_sort(0, 99, 1'b1, 1'b0, 4096, 4);
        checks++;
        if (m_state !== ST_WAIT_PART || m_depth != 3) begin
            errors++;
            $display("FAIL wait_part_setup got st=%0d dep=%0d want st=%0d dep=3", m_state, m_depth, ST_WAIT_PART);
        end
        init_lo = 16'd0;
        init_hi = 16'd5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checks++;
        if (m_state !== ST_WAIT_PART || m_depth != 3) begin
            errors++;
            $display("FAIL start_while_busy got st=%0d dep=%0d want st=%0d dep=3", m_state, m_depth, ST_WAIT_PART);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (m_state !== ST_IDLE || m_depth != 0 || m_valid !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got st=%0d dep=%0d v=%b b=%b want 0 0 0 0", m_state, m_depth, m_valid, m_busy);
        end
        pivot_idx = 16'd2;
        part_done = 1'b1;
        tick();
        part_done = 1'b0;
        checks++;
        if (m_state !== ST_IDLE || m_depth != 0) begin
            errors++;
            $display("FAIL stray_part_done got st=%0d dep=%0d want %0d 0", m_state, m_depth, ST_IDLE);
        end
        run_sort(2, 5, 1'b0, 1'b1, 4096, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        init_lo     = '0;
        init_hi     = '0;
        range_ready = 1'b0;
        part_done   = 1'b0;
        pivot_idx   = '0;
        sel_small   = 1'b0;
        test_reset();
        test_empty_range();
        test_basic();
        test_single_sided();
        test_full_sort();
        test_top_of_range();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
